thermo_encoder_sync: RTL

THERMO_ENCODER_SYNC -- requirements
Module: thermo_encoder_sync

---
 rtl/thermo_encoder_sync.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/thermo_encoder_sync.sv
// thermo_encoder_sync
// Debounced thermometer-to-binary encoder with a valid/ready output handshake.
// A 7-bit thermometer code must stay unchanged for STABLE_CYCLES sampled cycles
// before it is accepted. An accepted code is emitted only if it differs from the
// previously emitted one. Non-contiguous (bubble) codes are flagged on d_err.
//
// Optional feature macro: BUBBLE_CORRECT_EN
//   defined   : a bubble code reports d_out = popcount of the code, d_err = 1
//   undefined : a bubble code reports d_out = 0, d_err = 1
module thermo_encoder_sync #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] d_in,
  output logic [2:0] d_out,
  output logic       d_err,
  output logic       d_valid,
  input  logic       d_ready
);

  localparam logic [3:0] STABLE_N = 4'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  state_t     state_q;
  state_t     state_d;

  logic [6:0] s_reg;
  logic [3:0] cnt;
  logic [6:0] last_code;
  logic       last_vld;    // low means "no code emitted since reset"

  logic       load_first;  // IDLE -> SETTLE edge: fresh capture, counter cleared
  logic       sample;      // running capture while active
  logic       emit;        // load a new result into the output registers
  logic       xfer;        // consumer takes the current result

  // Number of ones in a 7-bit code.
  function automatic logic [2:0] popcount7(input logic [6:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 7; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

  // A legal thermometer code is a run of ones starting at bit 0 (zero allowed).
  function automatic logic is_thermo(input logic [6:0] v);
    return ((v & (v + 7'd1)) == 7'd0);
  endfunction

  // Stability counter increment that stops at the acceptance threshold.
  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= STABLE_N) ? STABLE_N : (c + 4'd1);
  endfunction

  // Binary value reported for a code, including the bubble policy.
  function automatic logic [2:0] encode(input logic [6:0] v);
    logic [2:0] r;
    if (is_thermo(v)) begin
      r = popcount7(v);
    end else begin
`ifdef BUBBLE_CORRECT_EN
      r = popcount7(v);
`else
      r = 3'd0;
`endif
    end
    return r;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_d    = state_q;
    load_first = 1'b0;
    sample     = 1'b0;
    emit       = 1'b0;
    xfer       = 1'b0;
    case (state_q)
      IDLE: begin
        if (en) begin
          load_first = 1'b1;
          state_d    = SETTLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_d = IDLE;
        end else begin
          sample = 1'b1;
          if ((cnt == STABLE_N) && (!last_vld || (s_reg != last_code))) begin
            emit    = 1'b1;
            state_d = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // Sampling continues so a code can settle while the consumer stalls;
        // dropping en does not abort the pending result.
        sample = en;
        if (d_ready) begin
          xfer    = 1'b1;
          state_d = en ? SETTLE : IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Input sampling and stability counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_reg <= 7'd0;
      cnt   <= 4'd0;
    end else if (load_first) begin
      s_reg <= d_in;
      cnt   <= 4'd0;
    end else if (sample) begin
      s_reg <= d_in;
      cnt   <= (d_in != s_reg) ? 4'd0 : sat_inc(cnt);
    end
  end

  // Result registers and memory of the last emitted code.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out     <= 3'd0;
      d_err     <= 1'b0;
      d_valid   <= 1'b0;
      last_code <= 7'd0;
      last_vld  <= 1'b0;
    end else if (emit) begin
      d_out     <= encode(s_reg);
      d_err     <= ~is_thermo(s_reg);
      d_valid   <= 1'b1;
      last_code <= s_reg;
      last_vld  <= 1'b1;
    end else if (xfer) begin
      d_valid   <= 1'b0;
    end
  end

endmodule
